// File: rtl/seq_framer_pkg.sv
// rtl/seq_framer_pkg.sv - shared types, constants and helpers for the sequence framer
package seq_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEQ  = 2'd2,
        DATA = 2'd3
    } state_e;

    localparam int NUM_STREAMS  = 32;
    localparam int HDR_BYTES    = 8;
    localparam int MAX_BYTES    = 37;
    localparam int WORD_BYTES   = 4;
    localparam int STREAM_IDX_W = 5;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] stream;
    } hdr_word_t;

    function automatic logic [3:0] words_for_len(input logic [5:0] len);
        logic [6:0] t;
        t = {1'b0, len} + 7'd3;
        return t[5:2];
    endfunction

endpackage

// File: rtl/seq_framer_seq_table.sv
// rtl/seq_framer_seq_table.sv - per-stream sequence register file, read comb, write adds increment
module seq_table
    import seq_framer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic [STREAM_IDX_W-1:0] idx_i,
    input  logic                    wr_en_i,
    input  logic [1:0]              inc_i,
    output logic [31:0]             rd_data_o
);

    logic [31:0] mem_q [NUM_STREAMS];

    assign rd_data_o = mem_q[idx_i];

    always_ff @(posedge clk) begin
        if (reset_b) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[idx_i] <= mem_q[idx_i] + {30'd0, inc_i};
        end
    end

endmodule

// File: rtl/seq_framer.sv
// rtl/seq_framer.sv - frames a payload as length/stream, sequence and data words
// Optional feature macro: SEQ_SKIP_INJECT_EN adds skipSeq to force a sequence gap.
module seq_framer
    import seq_framer_pkg::*;
(
    input  logic          clk,
    input  logic          reset_b,
    input  logic [0:295]  pktIn,
    input  logic [5:0]    pktIn_len,
    input  logic [15:0]   pktIn_stream,
    input  logic          pktIn_val,
`ifdef SEQ_SKIP_INJECT_EN
    input  logic          skipSeq,
`endif
    output logic          pktIn_ready,
    output logic [31:0]   dataOut,
    output logic          dataOut_val,
    input  logic          dataOut_ready,
    output logic          dataOut_last,
    output logic          lenErr
);

    state_e       state_q, state_d;
    logic [3:0]   k_q, k_d;
    logic         len_err_q, len_err_d;
    // Padded so every word-select of the last partial word stays in range.
    logic [0:319] payload_q;
    logic [5:0]   len_q;
    logic [15:0]  stream_q;
    logic [31:0]  seq_q;

    logic         take, len_ok, accept, last_word;
    logic [1:0]   inc;
    logic [31:0]  tbl_rd;
    logic [5:0]   byte_idx;
    hdr_word_t    hdr;

    assign pktIn_ready = (state_q == IDLE) && !reset_b;
    assign take        = pktIn_ready && pktIn_val;
    assign len_ok      = (pktIn_len != 6'd0) && (pktIn_len <= 6'(MAX_BYTES));
    assign accept      = take && len_ok;
    assign lenErr      = len_err_q;
    assign last_word   = (k_q == words_for_len(len_q) - 4'd1);

`ifdef SEQ_SKIP_INJECT_EN
    assign inc = skipSeq ? 2'd2 : 2'd1;
`else
    assign inc = 2'd1;
`endif

    seq_table u_seq_table (
        .clk       (clk),
        .reset_b   (reset_b),
        .idx_i     (pktIn_stream[STREAM_IDX_W-1:0]),
        .wr_en_i   (accept),
        .inc_i     (inc),
        .rd_data_o (tbl_rd)
    );

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q   <= IDLE;
            k_q       <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            len_err_q <= len_err_d;
            if (accept) begin
                payload_q <= {pktIn, 24'd0};
                len_q     <= pktIn_len;
                stream_q  <= pktIn_stream;
                seq_q     <= tbl_rd + {30'd0, inc};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        len_err_d    = take && !len_ok;
        dataOut      = '0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        byte_idx     = '0;
        hdr.len      = 16'(len_q) + 16'(HDR_BYTES);
        hdr.stream   = stream_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                dataOut     = hdr;
                dataOut_val = 1'b1;
                if (dataOut_ready) begin
                    state_d = SEQ;
                end
            end
            SEQ: begin
                dataOut     = seq_q;
                dataOut_val = 1'b1;
                if (dataOut_ready) begin
                    state_d = DATA;
                    k_d     = '0;
                end
            end
            DATA: begin
                dataOut_val  = 1'b1;
                dataOut_last = last_word;
                for (int b = 0; b < WORD_BYTES; b++) begin
                    byte_idx = {k_q, 2'b00} + 6'(b);
                    if (byte_idx < len_q) begin
                        dataOut[31-8*b -: 8] = payload_q[8*byte_idx +: 8];
                    end
                end
                if (dataOut_ready) begin
                    if (last_word) begin
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_framer.sv
// tb/tb_seq_framer.sv - directed self-checking bench for seq_framer
module tb_seq_framer;

    logic         clk = 1'b0;
    logic         reset_b;
    logic [0:295] pktIn;
    logic [5:0]   pktIn_len;
    logic [15:0]  pktIn_stream;
    logic         pktIn_val;
`ifdef SEQ_SKIP_INJECT_EN
    logic         skipSeq;
`endif
    logic         pktIn_ready;
    logic [31:0]  dataOut;
    logic         dataOut_val;
    logic         dataOut_ready;
    logic         dataOut_last;
    logic         lenErr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_w [16];
    logic        got_l [16];
    int          got_n;
    int          first_lat;

    always #5 clk = ~clk;

    seq_framer dut (
        .clk           (clk),
        .reset_b       (reset_b),
        .pktIn         (pktIn),
        .pktIn_len     (pktIn_len),
        .pktIn_stream  (pktIn_stream),
        .pktIn_val     (pktIn_val),
`ifdef SEQ_SKIP_INJECT_EN
        .skipSeq       (skipSeq),
`endif
        .pktIn_ready   (pktIn_ready),
        .dataOut       (dataOut),
        .dataOut_val   (dataOut_val),
        .dataOut_ready (dataOut_ready),
        .dataOut_last  (dataOut_last),
        .lenErr        (lenErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] len, input logic [15:0] stream,
                        input logic [7:0] base, input bit skip);
        logic [0:295] pk;
        for (int n = 0; n < 37; n++) begin
            pk[8*n +: 8] = (n < int'(len)) ? base + 8'(n) : 8'hAA;
        end
        pktIn        = pk;
        pktIn_len    = len;
        pktIn_stream = stream;
`ifdef SEQ_SKIP_INJECT_EN
        skipSeq      = skip;
`else
        if (skip) $display("note: skip request ignored in this build");
`endif
        check("ready_before_send", {31'd0, pktIn_ready}, 32'd1);
        pktIn_val = 1'b1;
        tick();
        pktIn_val = 1'b0;
    endtask

    task automatic collect(input int stall_at);
        bit done = 0;
        int cyc = 0;
        logic [31:0] hw;
        logic        hl;
        got_n     = 0;
        first_lat = -1;
        while (!done && cyc < 100) begin
            if (dataOut_val) begin
                if (first_lat < 0) first_lat = cyc;
                if (got_n == stall_at) begin
                    dataOut_ready = 1'b0;
                    hw = dataOut;
                    hl = dataOut_last;
                    repeat (3) begin
                        tick();
                        check("stall_word", dataOut, hw);
                        check("stall_val", {31'd0, dataOut_val}, 32'd1);
                        check("stall_last", {31'd0, dataOut_last}, {31'd0, hl});
                        check("stall_pkt_ready", {31'd0, pktIn_ready}, 32'd0);
                    end
                    dataOut_ready = 1'b1;
                end
                if (got_n < 16) begin
                    got_w[got_n] = dataOut;
                    got_l[got_n] = dataOut_last;
                end
                got_n++;
                if (dataOut_last) done = 1;
            end
            tick();
            cyc++;
        end
        check("collect_done", {31'd0, done}, 32'd1);
    endtask

    task automatic verify(input string tag, input logic [5:0] len, input logic [15:0] stream,
                          input logic [7:0] base, input logic [31:0] seq);
        int nw;
        logic [31:0] w;
        int idx;
        nw = 2 + (int'(len) + 3) / 4;
        check({tag, "_count"}, 32'(got_n), 32'(nw));
        check({tag, "_latency"}, 32'(first_lat), 32'd0);
        if (got_n == nw) begin
            check({tag, "_hdr"}, got_w[0], {16'(len) + 16'd8, stream});
            check({tag, "_seq"}, got_w[1], seq);
            for (int i = 0; i < nw - 2; i++) begin
                w = '0;
                for (int b = 0; b < 4; b++) begin
                    idx = 4 * i + b;
                    w = {w[23:0], (idx < int'(len)) ? base + 8'(idx) : 8'h00};
                end
                check({tag, "_data"}, got_w[i + 2], w);
            end
            for (int i = 0; i < nw; i++) begin
                check({tag, "_last"}, {31'd0, got_l[i]}, {31'd0, i == nw - 1});
            end
        end
    endtask

    task automatic frame(input string tag, input logic [5:0] len, input logic [15:0] stream,
                         input logic [7:0] base, input logic [31:0] seq);
        send(len, stream, base, 1'b0);
        collect(-1);
        verify(tag, len, stream, base, seq);
    endtask

    initial begin
        reset_b       = 1'b1;
        pktIn         = '0;
        pktIn_len     = '0;
        pktIn_stream  = '0;
        pktIn_val     = 1'b0;
        dataOut_ready = 1'b1;
`ifdef SEQ_SKIP_INJECT_EN
        skipSeq       = 1'b0;
`endif
        repeat (3) tick();
        check("rst_val", {31'd0, dataOut_val}, 32'd0);
        check("rst_last", {31'd0, dataOut_last}, 32'd0);
        check("rst_data", dataOut, 32'd0);
        check("rst_lenerr", {31'd0, lenErr}, 32'd0);
        reset_b = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, pktIn_ready}, 32'd1);

        // Hand-computed first packet.
        send(6'd5, 16'h0003, 8'h01, 1'b0);
        collect(-1);
        check("p1_count", 32'(got_n), 32'd4);
        check("p1_lat", 32'(first_lat), 32'd0);
        check("p1_w0", got_w[0], 32'h000D0003);
        check("p1_w1", got_w[1], 32'h00000001);
        check("p1_w2", got_w[2], 32'h01020304);
        check("p1_w3", got_w[3], 32'h05000000);
        check("p1_l2", {31'd0, got_l[2]}, 32'd0);
        check("p1_l3", {31'd0, got_l[3]}, 32'd1);
        frame("p2", 6'd5, 16'h0003, 8'h01, 32'd2);

        // Maximum length.
        frame("max", 6'd37, 16'h0010, 8'h00, 32'd1);
        check("max_hdr", got_w[0], 32'h002D0010);
        check("max_w11", got_w[11], 32'h24000000);

        // Backpressure on the second data word.
        send(6'd9, 16'h0009, 8'h40, 1'b0);
        collect(3);
        verify("bp", 6'd9, 16'h0009, 8'h40, 32'd1);

        // Illegal lengths.
        send(6'd0, 16'h0005, 8'h10, 1'b0);
        check("len0_err", {31'd0, lenErr}, 32'd1);
        check("len0_val", {31'd0, dataOut_val}, 32'd0);
        tick();
        check("len0_err_pulse", {31'd0, lenErr}, 32'd0);
        check("len0_val2", {31'd0, dataOut_val}, 32'd0);
        send(6'd38, 16'h0005, 8'h10, 1'b0);
        check("len38_err", {31'd0, lenErr}, 32'd1);
        check("len38_val", {31'd0, dataOut_val}, 32'd0);
        tick();
        check("len38_err_pulse", {31'd0, lenErr}, 32'd0);
        frame("after_err", 6'd3, 16'h0005, 8'h10, 32'd1);

        // Aliased streams share one counter.
        frame("alias1", 6'd4, 16'h0001, 8'h20, 32'd1);
        frame("alias2", 6'd4, 16'h0021, 8'h30, 32'd2);
        frame("alias3", 6'd2, 16'h0001, 8'h50, 32'd3);
        frame("alias4", 6'd8, 16'h0021, 8'h60, 32'd4);

        // Reset mid-packet aborts without last.
        send(6'd8, 16'h0001, 8'h70, 1'b0);
        check("abort_hdr_val", {31'd0, dataOut_val}, 32'd1);
        check("abort_hdr_last", {31'd0, dataOut_last}, 32'd0);
        tick();
        check("abort_seq_word", dataOut, 32'd5);
        check("abort_seq_last", {31'd0, dataOut_last}, 32'd0);
        reset_b = 1'b1;
        tick();
        check("abort_val", {31'd0, dataOut_val}, 32'd0);
        check("abort_last", {31'd0, dataOut_last}, 32'd0);
        reset_b = 1'b0;
        tick();
        frame("post_rst_a", 6'd1, 16'h0021, 8'h80, 32'd1);
        frame("post_rst_b", 6'd6, 16'h0003, 8'h90, 32'd1);

`ifdef SEQ_SKIP_INJECT_EN
        send(6'd4, 16'h0007, 8'h11, 1'b0);
        collect(-1);
        check("skip_seq1", got_w[1], 32'd1);
        send(6'd4, 16'h0007, 8'h11, 1'b1);
        collect(-1);
        check("skip_seq2", got_w[1], 32'd3);
        send(6'd4, 16'h0007, 8'h11, 1'b0);
        collect(-1);
        check("skip_seq3", got_w[1], 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
